// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative 32-bit multiply/divide beside the EX-stage ALU.
// It owns the HI/LO registers, stalls the front of the pipeline while an
// operation is in flight, and serves MTHI/MTLO writes when idle.
module ex_muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] op1_E,
    input  logic [31:0] op2_E,
    input  logic        kill,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        hilo_rd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] r_b;         // mul: multiplicand magnitude; div: divisor magnitude
    logic [31:0] r_a_raw;     // raw dividend, returned in HI on divide by zero
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_is_div;
    logic        r_b_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_signed;
    logic        w_is_div;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_rem;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    assign w_signed = md_op[0];
    assign w_is_div = md_op[1];
    assign w_mag_a  = (w_signed && op1_E[31]) ? -op1_E : op1_E;
    assign w_mag_b  = (w_signed && op2_E[31]) ? -op2_E : op2_E;

    // One radix-2 shift-add step: add multiplicand to the upper half when the
    // current multiplier bit is set, then shift the whole 64-bit pair right.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // One restoring-divide step: shift the next dividend bit into the
    // remainder and subtract the divisor when it fits.
    assign w_div_rem  = {r_acc[63:32], r_acc[31]};
    assign w_div_ge   = (w_div_rem >= {1'b0, r_b});
    assign w_div_diff = w_div_rem[31:0] - r_b;
    assign w_div_next = {(w_div_ge ? w_div_diff : w_div_rem[31:0]), r_acc[30:0], w_div_ge};

    // Sign correction of the unsigned magnitude results.
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
    assign w_quot_fix = (r_sign_a ^ r_sign_b) ? -r_acc[31:0] : r_acc[31:0];
    assign w_rem_fix  = r_sign_a ? -r_acc[63:32] : r_acc[63:32];

    // Next-state logic; kill returns to IDLE from any state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_CALC;
            S_CALC: if (r_cnt == 5'(ITER - 1)) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (kill) w_state_next = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Datapath: operand latch, iteration, result write-back and MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_a_raw  <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_is_div <= 1'b0;
            r_b_zero <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start && !kill) begin
                        r_cnt    <= '0;
                        r_is_div <= w_is_div;
                        r_sign_a <= w_signed & op1_E[31];
                        r_sign_b <= w_signed & op2_E[31];
                        r_a_raw  <= op1_E;
                        r_b_zero <= (op2_E == 32'd0);
                        r_b      <= w_is_div ? w_mag_b : w_mag_a;
                        r_acc    <= {32'd0, (w_is_div ? w_mag_a : w_mag_b)};
                    end
                end
                S_CALC: begin
                    if (!kill) begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_FIX: begin
                    if (!kill) begin
                        r_done <= 1'b1;
                        if (!r_is_div) begin
                            r_hi <= w_prod_fix[63:32];
                            r_lo <= w_prod_fix[31:0];
                        end else if (r_b_zero) begin
                            r_hi <= r_a_raw;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign done  = r_done;
    assign busy  = (r_state != S_IDLE);
    assign stall = busy & (start | hilo_rd | hi_we | lo_we);

endmodule
